compare_monitor_4b: RTL and testbench
=====================================

Name: compare_monitor_4b

Overview:
- Downstream consumer of the 4-bit comparator's flag outputs (A_great_B, A_equal_B, A_less_B).
- Qualifies each flag sample with a valid strobe and keeps saturating per-outcome event counts.
- Runs a hysteresis FSM: raises a registered alarm after SET_CNT consecutive "greater" samples and clears it after CLR_CNT consecutive "not greater" samples.
- Sits between the comparator and status/LED logic.

Parameters:
- SET_CNT, 3: consecutive valid GT samples needed to raise the alarm; legal range 1..15.
- CLR_CNT, 2: consecutive valid EQ/LT samples needed to clear the alarm; legal range 1..15.
- CNT_W, 8: width of each event counter; must be at least 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  flag sample qualifier
- A_great_B  input  1  comparator GT flag
- A_equal_B  input  1  comparator EQ flag
- A_less_B  input  1  comparator LT flag
- alarm  output  1  registered hysteresis alarm level
- alarm_rise  output  1  one-cycle pulse on the 0->1 transition of alarm
- gt_count  output  CNT_W  saturating count of accepted GT samples
- eq_count  output  CNT_W  saturating count of accepted EQ samples
- lt_count  output  CNT_W  saturating count of accepted LT samples
- flag_err  output  1  sticky: an illegal flag pattern was seen while in_valid=1
- state  output  2  current FSM state, for debug

Behaviour:
- Interface: one clock domain; reset is synchronous and active-high.
- Reset values: all outputs 0, state=IDLE, internal run counter 0.
- rst dominates every other input at the clock edge, including mid-alarm.
- Sample acceptance: a sample is accepted when in_valid=1 and exactly one of the three flags is 1.
  - in_valid=0: nothing changes; FSM, run counter and counters hold. Gaps do not break a run.
  - in_valid=1 with a non-one-hot pattern (000, 110, 111, ...): flag_err is set. The sample is ignored by the FSM and all counters.
- Counters: an accepted sample increments its matching counter by 1. Each counter saturates at 2^CNT_W-1.
- Timing: all outputs are registered. Effects of a sample accepted on edge N are visible after edge N.
- State encoding: IDLE=0, ARMING=1, ALARM=2, CLEARING=3. "Accepted GT" and "accepted non-GT (EQ or LT)" below mean accepted samples only.
- IDLE:
  - Accepted GT: run=1; go to ARMING, or go directly to ALARM if SET_CNT=1.
  - Accepted non-GT: stay in IDLE.
- ARMING:
  - Accepted GT: run+1. When it reaches SET_CNT, go to ALARM and set run=0.
  - Accepted non-GT: go to IDLE, run=0.
- ALARM (alarm=1):
  - Accepted GT: stay.
  - Accepted non-GT: run=1; go to CLEARING, or go directly to IDLE if CLR_CNT=1.
- CLEARING (alarm=1):
  - Accepted non-GT: run+1. When it reaches CLR_CNT, go to IDLE and set run=0.
  - Accepted GT: go to ALARM, run=0.
- alarm = (state==ALARM or state==CLEARING).
- alarm_rise pulses for exactly the one cycle after any edge that enters ALARM from IDLE or ARMING. It does not pulse when entering ALARM from CLEARING.
- Run counter is 4 bits wide.

Optional Feature:
- Macro: CMP_MON_RISE_STAMP_EN.
- Defined:
  - Adds a free-running CNT_W-bit cycle counter, reset to 0, that wraps.
  - Adds output rise_stamp [CNT_W-1:0], reset 0, which captures the cycle counter value on every edge that raises alarm_rise.
- Undefined: rise_stamp port and cycle counter are absent; all other behaviour is identical.

Decomposition:
- Package cmp_mon_pkg holds:
  - state encodings IDLE/ARMING/ALARM/CLEARING as 2-bit localparams;
  - RUN_W=4;
  - default SET_CNT/CLR_CNT constants.
- Sub-module sat_counter: CNT_W-wide, synchronous active-high rst, inc enable, holds at all-ones. Instantiated three times, for gt/eq/lt.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with GT flags and in_valid=1 driven.
  - Required: all outputs 0, state=0; after release, nothing changes until the first accepted sample.
- Alarm raise (defaults):
  - Stimulus: three accepted GT samples on consecutive cycles.
  - Required: alarm=1 after the 3rd edge; alarm_rise=1 for exactly that cycle; gt_count=3; state=2.
- Broken run, with gaps:
  - Stimulus: GT, in_valid=0 for 2 cycles, GT, EQ, GT, GT.
  - Required: alarm never rises; gt_count=4, eq_count=1; state=1 at end.
- Hysteresis clear:
  - Stimulus: from ALARM, drive LT, GT, LT, LT.
  - Required: alarm stays 1 through LT and GT (state 3->2); drops after the final LT; lt_count=3; no alarm_rise during this sequence.
- Illegal flags:
  - Stimulus: in_valid=1 with flags 1,1,0, then with 0,0,0.
  - Required: flag_err=1 and stays 1; counters and state unchanged; flag_err clears only on rst.
- Saturation and mid-alarm reset:
  - Stimulus: CNT_W=4 with 20 accepted GT samples; then rst=1 for 1 cycle while in ALARM.
  - Required: gt_count=15 (held); all outputs 0 after the reset edge; with CMP_MON_RISE_STAMP_EN defined, rise_stamp=2 from the first rise after reset.

Source files
------------

// File: rtl/compare_monitor_4b_pkg.sv
// cmp_mon_pkg: shared state encodings and defaults for the comparator flag monitor
package cmp_mon_pkg;
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ARMING   = 2'd1;
    localparam logic [1:0] ALARM    = 2'd2;
    localparam logic [1:0] CLEARING = 2'd3;
    localparam int RUN_W       = 4;
    localparam int SET_CNT_DEF = 3;
    localparam int CLR_CNT_DEF = 2;
endpackage

// File: rtl/compare_monitor_4b_if.sv
// compare_monitor_4b_if: flag sample inputs and monitor status outputs; CMP_MON_RISE_STAMP_EN adds rise_stamp
interface compare_monitor_4b_if #(parameter int CNT_W = 8);
    logic             in_valid;
    logic             A_great_B;
    logic             A_equal_B;
    logic             A_less_B;
    logic             alarm;
    logic             alarm_rise;
    logic [CNT_W-1:0] gt_count;
    logic [CNT_W-1:0] eq_count;
    logic [CNT_W-1:0] lt_count;
    logic             flag_err;
    logic [1:0]       state;
`ifdef CMP_MON_RISE_STAMP_EN
    logic [CNT_W-1:0] rise_stamp;
    modport master (output in_valid, A_great_B, A_equal_B, A_less_B,
                    input alarm, alarm_rise, gt_count, eq_count, lt_count, flag_err, state, rise_stamp);
    modport slave  (input in_valid, A_great_B, A_equal_B, A_less_B,
                    output alarm, alarm_rise, gt_count, eq_count, lt_count, flag_err, state, rise_stamp);
`else
    modport master (output in_valid, A_great_B, A_equal_B, A_less_B,
                    input alarm, alarm_rise, gt_count, eq_count, lt_count, flag_err, state);
    modport slave  (input in_valid, A_great_B, A_equal_B, A_less_B,
                    output alarm, alarm_rise, gt_count, eq_count, lt_count, flag_err, state);
`endif
endinterface

// File: rtl/compare_monitor_4b_sat_counter.sv
// sat_counter: event counter that increments on inc_i and sticks at all-ones
module sat_counter #(parameter int W = 8) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q;
    // count up until saturated at all-ones
    always_ff @(posedge clk)
        if (rst) count_q <= '0;
        else if (inc_i && count_q != '1) count_q <= count_q + 1'b1;
    assign count_o = count_q;
endmodule

// File: rtl/compare_monitor_4b.sv
// compare_monitor_4b: qualifies comparator flags, counts outcomes, runs GT hysteresis alarm (option CMP_MON_RISE_STAMP_EN)
module compare_monitor_4b
    import cmp_mon_pkg::*;
#(
    parameter int SET_CNT = SET_CNT_DEF,
    parameter int CLR_CNT = CLR_CNT_DEF,
    parameter int CNT_W   = 8
) (
    input logic clk,
    input logic rst,
    compare_monitor_4b_if.slave bus
);
    logic [2:0]       flags;
    logic             one_hot, acc_gt, acc_ng;
    logic [1:0]       state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic             alarm_q, rise_q, err_q, rise_d;
    assign flags   = {bus.A_great_B, bus.A_equal_B, bus.A_less_B};
    assign one_hot = flags == 3'b100 || flags == 3'b010 || flags == 3'b001;
    assign acc_gt  = bus.in_valid && one_hot && bus.A_great_B;
    assign acc_ng  = bus.in_valid && one_hot && !bus.A_great_B;
    assign run_inc = run_q + 1'b1;
    // hysteresis next state: GT runs arm the alarm, non-GT runs clear it
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        case (state_q)
            IDLE: if (acc_gt) begin
                state_d = SET_CNT == 1 ? ALARM : ARMING;
                run_d   = SET_CNT == 1 ? '0 : RUN_W'(1);
            end
            ARMING: if (acc_gt) begin
                state_d = run_inc == RUN_W'(SET_CNT) ? ALARM : ARMING;
                run_d   = run_inc == RUN_W'(SET_CNT) ? '0 : run_inc;
            end else if (acc_ng) begin
                state_d = IDLE;
                run_d   = '0;
            end
            ALARM: if (acc_ng) begin
                state_d = CLR_CNT == 1 ? IDLE : CLEARING;
                run_d   = CLR_CNT == 1 ? '0 : RUN_W'(1);
            end
            default: if (acc_ng) begin
                state_d = run_inc == RUN_W'(CLR_CNT) ? IDLE : CLEARING;
                run_d   = run_inc == RUN_W'(CLR_CNT) ? '0 : run_inc;
            end else if (acc_gt) begin
                state_d = ALARM;
                run_d   = '0;
            end
        endcase
    end
    assign rise_d = state_d == ALARM && (state_q == IDLE || state_q == ARMING);
    // register FSM, alarm level, rise pulse and sticky illegal-pattern flag
    always_ff @(posedge clk)
        if (rst) begin
            state_q <= IDLE;
            run_q   <= '0;
            alarm_q <= 1'b0;
            rise_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            alarm_q <= state_d == ALARM || state_d == CLEARING;
            rise_q  <= rise_d;
            err_q   <= err_q || (bus.in_valid && !one_hot);
        end
    sat_counter #(.W(CNT_W)) u_gt (.clk(clk), .rst(rst), .inc_i(acc_gt), .count_o(bus.gt_count));
    sat_counter #(.W(CNT_W)) u_eq (.clk(clk), .rst(rst), .inc_i(acc_ng && bus.A_equal_B), .count_o(bus.eq_count));
    sat_counter #(.W(CNT_W)) u_lt (.clk(clk), .rst(rst), .inc_i(acc_ng && bus.A_less_B), .count_o(bus.lt_count));
`ifdef CMP_MON_RISE_STAMP_EN
    logic [CNT_W-1:0] cyc_q, stamp_q;
    // free-running cycle counter, sampled whenever the alarm rises
    always_ff @(posedge clk)
        if (rst) begin
            cyc_q   <= '0;
            stamp_q <= '0;
        end else begin
            cyc_q   <= cyc_q + 1'b1;
            stamp_q <= rise_d ? cyc_q : stamp_q;
        end
    assign bus.rise_stamp = stamp_q;
`endif
    assign bus.alarm      = alarm_q;
    assign bus.alarm_rise = rise_q;
    assign bus.flag_err   = err_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_compare_monitor_4b.sv
// tb_compare_monitor_4b: randomized + directed scoreboard bench against a run-length alarm model
module tb_compare_monitor_4b;
    localparam int CW   = 4;
    localparam int SETN = 3;
    localparam int CLRN = 2;
    localparam int MAXC = (1 << CW) - 1;
    typedef struct {
        logic          alarm, rise, err;
        logic [1:0]    st;
        logic [CW-1:0] gt, eq, lt, stamp;
    } exp_t;
    logic clk, rst;
    exp_t q[$];
    int vectors = 0, miscompares = 0;
    int m_run, m_gt, m_eq, m_lt, m_cyc, m_stamp;
    bit m_alarm, m_err, m_rise;
    compare_monitor_4b_if #(.CNT_W(CW)) bus ();
    compare_monitor_4b #(.SET_CNT(SETN), .CLR_CNT(CLRN), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    task automatic step(input bit r, input bit v, input bit g, input bit e, input bit l);
        exp_t x;
        @(negedge clk);
        rst = r;
        bus.in_valid = v;
        bus.A_great_B = g;
        bus.A_equal_B = e;
        bus.A_less_B = l;
        m_rise = 0;
        if (r) begin
            m_alarm = 0; m_run = 0; m_gt = 0; m_eq = 0; m_lt = 0;
            m_err = 0; m_cyc = 0; m_stamp = 0;
        end else begin
            if (v && int'(g) + int'(e) + int'(l) == 1) begin
                if (g) m_gt = m_gt < MAXC ? m_gt + 1 : MAXC;
                if (e) m_eq = m_eq < MAXC ? m_eq + 1 : MAXC;
                if (l) m_lt = m_lt < MAXC ? m_lt + 1 : MAXC;
                // run counts consecutive samples pushing toward the opposite alarm level
                if (g != m_alarm) begin
                    m_run++;
                    if (m_run >= (m_alarm ? CLRN : SETN)) begin
                        m_alarm = !m_alarm;
                        m_rise = m_alarm;
                        m_run = 0;
                    end
                end else m_run = 0;
            end else if (v) m_err = 1;
            if (m_rise) m_stamp = m_cyc;
            m_cyc = (m_cyc + 1) % (MAXC + 1);
        end
        x.alarm = m_alarm;
        x.rise  = m_rise;
        x.err   = m_err;
        x.st    = m_alarm ? (m_run > 0 ? 2'd3 : 2'd2) : (m_run > 0 ? 2'd1 : 2'd0);
        x.gt    = CW'(m_gt);
        x.eq    = CW'(m_eq);
        x.lt    = CW'(m_lt);
        x.stamp = CW'(m_stamp);
        q.push_back(x);
    endtask
    task automatic chk(input string name, input int v, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", name, v, act, exp);
        end
    endtask
    // monitor: one expected entry per clock edge, sampled 1ns after it
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                vectors++;
                chk("alarm", vectors, 32'(bus.alarm), 32'(x.alarm));
                chk("alarm_rise", vectors, 32'(bus.alarm_rise), 32'(x.rise));
                chk("flag_err", vectors, 32'(bus.flag_err), 32'(x.err));
                chk("state", vectors, 32'(bus.state), 32'(x.st));
                chk("gt_count", vectors, 32'(bus.gt_count), 32'(x.gt));
                chk("eq_count", vectors, 32'(bus.eq_count), 32'(x.eq));
                chk("lt_count", vectors, 32'(bus.lt_count), 32'(x.lt));
`ifdef CMP_MON_RISE_STAMP_EN
                chk("rise_stamp", vectors, 32'(bus.rise_stamp), 32'(x.stamp));
`endif
            end
        end
    end
    initial begin
        bit v;
        logic [2:0] f;
        rst = 1;
        bus.in_valid = 0;
        bus.A_great_B = 0;
        bus.A_equal_B = 0;
        bus.A_less_B = 0;
        repeat (2) step(1, 1, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        repeat (3) step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 1); step(0, 1, 1, 0, 0); step(0, 1, 0, 0, 1); step(0, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0); step(0, 0, 1, 0, 0); step(0, 0, 0, 0, 0); step(0, 1, 1, 0, 0);
        step(0, 1, 0, 1, 0); step(0, 1, 1, 0, 0); step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0); step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 0); step(0, 1, 1, 1, 1);
        step(1, 0, 0, 0, 0);
        repeat (20) step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        repeat (4) step(0, 1, 1, 0, 0);
        repeat (5) step(0, 1, 0, 1, 0);
        for (int i = 0; i < 400; i++) begin
            v = $urandom_range(3) != 0;
            f = $urandom_range(4) != 0 ? 3'b001 << $urandom_range(2) : 3'($urandom);
            step($urandom_range(60) == 0, v, f[2], f[1], f[0]);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
